// File: rtl/multi_led_blinker.sv
// Multi-channel LED driver: one shared tick prescaler feeding N independent
// channels that each run OFF, ON, PWM or a finite burst of PWM periods.
module multi_led_blinker #(
  parameter int CHANNELS     = 4,
  parameter int CLK_FREQ_KHz = 50000,
  parameter int TICK_HZ      = 1000,
  parameter int PERIOD_W     = 12,
  parameter int BURST_W      = 8
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              cfg_valid,
  output logic                                              cfg_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [1:0]                                        cfg_mode,
  input  logic [PERIOD_W-1:0]                               cfg_period,
  input  logic [PERIOD_W-1:0]                               cfg_duty,
  input  logic [BURST_W-1:0]                                cfg_count,
  output logic [CHANNELS-1:0]                               led,
  output logic [CHANNELS-1:0]                               busy
);

  localparam int PRESCALE = (CLK_FREQ_KHz * 1000) / TICK_HZ;
  localparam int PS_W     = $clog2(PRESCALE);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_PWM   = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  logic [PS_W-1:0]     presc_q, presc_d;
  logic                tick;
  logic                accept;
  logic                ready_q;
  mode_e               mode_q   [CHANNELS];
  mode_e               mode_d   [CHANNELS];
  logic [PERIOD_W-1:0] period_q [CHANNELS];
  logic [PERIOD_W-1:0] period_d [CHANNELS];
  logic [PERIOD_W-1:0] duty_q   [CHANNELS];
  logic [PERIOD_W-1:0] duty_d   [CHANNELS];
  logic [PERIOD_W-1:0] phase_q  [CHANNELS];
  logic [PERIOD_W-1:0] phase_d  [CHANNELS];
  logic [BURST_W-1:0]  burst_q  [CHANNELS];
  logic [BURST_W-1:0]  burst_d  [CHANNELS];
  logic [CHANNELS-1:0] led_q, led_d, busy_q, busy_d;

  always_comb begin
    tick    = (presc_q == PS_W'(PRESCALE - 1));
    presc_d = tick ? '0 : presc_q + PS_W'(1);
    accept  = cfg_valid && ready_q;
    for (int i = 0; i < CHANNELS; i++) begin
      mode_d[i]   = mode_q[i];
      period_d[i] = period_q[i];
      duty_d[i]   = duty_q[i];
      phase_d[i]  = phase_q[i];
      burst_d[i]  = burst_q[i];
      led_d[i]    = 1'b0;
      busy_d[i]   = 1'b0;
      // A config write wins over a coincident tick; out-of-range channels never match.
      if (accept && (int'(cfg_ch) == i)) begin
        mode_d[i]   = ((cfg_mode == 2'd3) && (cfg_count == '0)) ? MODE_OFF : mode_e'(cfg_mode);
        period_d[i] = cfg_period;
        duty_d[i]   = cfg_duty;
        phase_d[i]  = '0;
        burst_d[i]  = cfg_count;
      end else if (tick && ((mode_q[i] == MODE_PWM) || (mode_q[i] == MODE_BURST)) &&
                   (period_q[i] != '0)) begin
        if (phase_q[i] == period_q[i] - PERIOD_W'(1)) begin
          phase_d[i] = '0;
          if (mode_q[i] == MODE_BURST) begin
            burst_d[i] = burst_q[i] - BURST_W'(1);
            if (burst_q[i] == BURST_W'(1)) mode_d[i] = MODE_OFF;
          end
        end else begin
          phase_d[i] = phase_q[i] + PERIOD_W'(1);
        end
      end
      led_d[i]  = (mode_d[i] == MODE_ON) ||
                  (((mode_d[i] == MODE_PWM) || (mode_d[i] == MODE_BURST)) &&
                   (period_d[i] != '0) && (phase_d[i] < duty_d[i]));
      busy_d[i] = (mode_d[i] == MODE_BURST) && (burst_d[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      ready_q <= 1'b0;
      led_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= '0;
        duty_q[i]   <= '0;
        phase_q[i]  <= '0;
        burst_q[i]  <= '0;
      end
    end else begin
      presc_q <= presc_d;
      ready_q <= 1'b1;
      led_q   <= led_d;
      busy_q  <= busy_d;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= mode_d[i];
        period_q[i] <= period_d[i];
        duty_q[i]   <= duty_d[i];
        phase_q[i]  <= phase_d[i];
        burst_q[i]  <= burst_d[i];
      end
    end
  end

  assign cfg_ready = ready_q;
  assign led       = led_q;
  assign busy      = busy_q;

endmodule
